// File: rtl/nco_channel_scheduler.sv
// Round-robin scheduler sharing one quadrature sine lookup among NCH NCO channels; optional phase dither via NCO_DITHER_EN.
// Latency: a phase issued in cycle t returns as a tagged sample (o_valid/o_ch/o_i/o_q) in cycle t+LUT_LAT+1.
// Backpressure: none on the sample path; config writes are held off (o_cfg_ready=0) while the lookup pipe flushes.
module nco_channel_scheduler #(
    parameter int NCH     = 4,
    parameter int PW      = 12,
    parameter int AW      = 32,
    parameter int OW      = 16,
    parameter int LUT_LAT = 5,
    parameter int CW      = $clog2(NCH)
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_en,
    input  logic                 i_sync,
    input  logic                 i_cfg_valid,
    output logic                 o_cfg_ready,
    input  logic [CW-1:0]        i_cfg_ch,
    input  logic [AW-1:0]        i_cfg_fcw,
    input  logic [PW-1:0]        i_cfg_phoff,
    output logic                 o_lut_ce,
    output logic [PW-1:0]        o_lut_phase,
    input  logic signed [OW:0]   i_lut_i,
    input  logic signed [OW:0]   i_lut_q,
    output logic                 o_valid,
    output logic [CW-1:0]        o_ch,
    output logic signed [OW:0]   o_i,
    output logic signed [OW:0]   o_q
);

    localparam int FW = $clog2(LUT_LAT + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    state_e                      state_q, state_d;
    logic [FW-1:0]               flush_cnt_q, flush_cnt_d;
    logic [CW-1:0]               slot_q, slot_d;
    logic [AW-1:0]               acc_q [NCH];
    logic [AW-1:0]               acc_d [NCH];
    logic [AW-1:0]               fcw_q [NCH];
    logic [AW-1:0]               fcw_d [NCH];
    logic [PW-1:0]               phoff_q [NCH];
    logic [PW-1:0]               phoff_d [NCH];
    logic                        cfg_ready_q, cfg_ready_d;
    logic [LUT_LAT-1:0]          tag_vld_q, tag_vld_d;
    logic [LUT_LAT-1:0][CW-1:0]  tag_ch_q, tag_ch_d;
    logic                        out_vld_q, out_vld_d;
    logic [CW-1:0]               out_ch_q, out_ch_d;
    logic signed [OW:0]          out_i_q, out_i_d;
    logic signed [OW:0]          out_q_q, out_q_d;

    logic                        run;
    logic                        lut_ce;
    logic                        cfg_accept;
    logic [PW-1:0]               phase_top;

    assign run        = (state_q == ST_RUN);
    assign lut_ce     = (state_q != ST_IDLE);
    assign cfg_accept = i_cfg_valid & cfg_ready_q;

    // ------------------------------------------------------------------
    // Run/flush control
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (i_en) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!i_en) begin
                    state_d     = ST_FLUSH;
                    flush_cnt_d = '0;
                end
            end
            ST_FLUSH: begin
                if (i_en) begin
                    state_d = ST_RUN;
                end else if (flush_cnt_q == FW'(LUT_LAT - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    flush_cnt_d = flush_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Ready reflects the previous cycle's state, so it trails FLUSH entry/exit by one cycle.
    assign cfg_ready_d = (state_q != ST_FLUSH);

    always_comb begin
        slot_d = slot_q;
        if (run) begin
            slot_d = (slot_q == CW'(NCH - 1)) ? '0 : slot_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Phase generation (issued phase always comes from the pre-add accumulator)
    // ------------------------------------------------------------------
`ifdef NCO_DITHER_EN
    logic [15:0] lfsr_q, lfsr_d;
    logic [AW-1:0] dith_sum;

    assign lfsr_d   = run ? {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]}
                          : lfsr_q;
    assign dith_sum = acc_q[slot_q] + (AW'(lfsr_q) << (AW - PW - 16));
    assign phase_top = dith_sum[AW-1 -: PW];

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    assign phase_top = acc_q[slot_q][AW-1 -: PW];
`endif

    assign o_lut_phase = run ? (phase_top + phoff_q[slot_q]) : '0;

    // ------------------------------------------------------------------
    // Per-channel state: accumulate, sync, configuration
    // ------------------------------------------------------------------
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            acc_d[c]   = acc_q[c];
            fcw_d[c]   = fcw_q[c];
            phoff_d[c] = phoff_q[c];
            if (i_sync) begin
                acc_d[c] = '0;
            end else if (run && (slot_q == CW'(c))) begin
                acc_d[c] = acc_q[c] + fcw_q[c];
            end
            // A target index with no matching channel simply falls through and is dropped.
            if (cfg_accept && (i_cfg_ch == CW'(c))) begin
                fcw_d[c]   = i_cfg_fcw;
                phoff_d[c] = i_cfg_phoff;
            end
        end
    end

    // ------------------------------------------------------------------
    // Tag pipe and output register, both advancing only with the lookup enable
    // ------------------------------------------------------------------
    always_comb begin
        tag_vld_d = tag_vld_q;
        tag_ch_d  = tag_ch_q;
        out_vld_d = 1'b0;
        out_ch_d  = out_ch_q;
        out_i_d   = out_i_q;
        out_q_d   = out_q_q;
        if (lut_ce) begin
            for (int k = LUT_LAT - 1; k > 0; k--) begin
                tag_vld_d[k] = tag_vld_q[k-1];
                tag_ch_d[k]  = tag_ch_q[k-1];
            end
            tag_vld_d[0] = run;
            tag_ch_d[0]  = slot_q;
            out_vld_d    = tag_vld_q[LUT_LAT-1];
            out_ch_d     = tag_ch_q[LUT_LAT-1];
            out_i_d      = i_lut_i;
            out_q_d      = i_lut_q;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q     <= ST_IDLE;
            flush_cnt_q <= '0;
            slot_q      <= '0;
            cfg_ready_q <= 1'b0;
            tag_vld_q   <= '0;
            tag_ch_q    <= '0;
            out_vld_q   <= 1'b0;
            out_ch_q    <= '0;
            out_i_q     <= '0;
            out_q_q     <= '0;
            for (int c = 0; c < NCH; c++) begin
                acc_q[c]   <= '0;
                fcw_q[c]   <= '0;
                phoff_q[c] <= '0;
            end
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            slot_q      <= slot_d;
            cfg_ready_q <= cfg_ready_d;
            tag_vld_q   <= tag_vld_d;
            tag_ch_q    <= tag_ch_d;
            out_vld_q   <= out_vld_d;
            out_ch_q    <= out_ch_d;
            out_i_q     <= out_i_d;
            out_q_q     <= out_q_d;
            for (int c = 0; c < NCH; c++) begin
                acc_q[c]   <= acc_d[c];
                fcw_q[c]   <= fcw_d[c];
                phoff_q[c] <= phoff_d[c];
            end
        end
    end

    assign o_cfg_ready = cfg_ready_q;
    assign o_lut_ce    = lut_ce;
    assign o_valid     = out_vld_q;
    assign o_ch        = out_ch_q;
    assign o_i         = out_i_q;
    assign o_q         = out_q_q;

endmodule

// File: doc/nco_channel_scheduler.md
# nco_channel_scheduler

Time-multiplexes one shared quadrature sine lookup among `NCH` independent NCO channels. Each channel has its own phase accumulator, frequency control word and phase offset. The block issues one channel's phase per cycle to the lookup in round-robin order and tags the returned I/Q samples with their channel number. It sits between the configuration/control interface and the sine lookup in the IQ modulator front end.

## Interface
- `NCH`, 4: number of channels, power of two, 2..16
- `PW`, 12: phase width presented to the lookup
- `AW`, 32: accumulator and FCW width; must satisfy AW−PW ≥ 16
- `OW`, 16: lookup magnitude width; samples are OW+1 bits signed
- `LUT_LAT`, 5: lookup latency in `ce`-qualified cycles
- `CW`, $clog2(NCH): channel index width

- `i_clk`  in  1  single clock; all logic on rising edge
- `i_reset_n`  in  1  asynchronous, active-low reset
- `i_en`  in  1  run request
- `i_sync`  in  1  single-cycle pulse; zeroes all accumulators
- `i_cfg_valid`  in  1  config write request
- `o_cfg_ready`  out  1  config write accepted when high together with valid
- `i_cfg_ch`  in  CW  target channel
- `i_cfg_fcw`  in  AW  frequency control word
- `i_cfg_phoff`  in  PW  phase offset
- `o_lut_ce`  out  1  lookup clock enable
- `o_lut_phase`  out  PW  phase to lookup
- `i_lut_i`, `i_lut_q`  in  OW+1  signed samples from lookup
- `o_valid`  out  1  output sample valid
- `o_ch`  out  CW  channel of output sample
- `o_i`, `o_q`  out  OW+1  signed I/Q output

## Operation
- Reset: state IDLE; all accumulators, FCWs, offsets, slot counter and tag pipe cleared; every output 0, including `o_cfg_ready`.
- FSM: IDLE → RUN when `i_en`=1. RUN → FLUSH when `i_en`=0. FLUSH → IDLE after LUT_LAT cycles. FLUSH → RUN if `i_en` returns high during FLUSH; the slot counter continues without reset.
- RUN, each cycle, with slot s:
  - `o_lut_phase` = acc[s][AW−1 −: PW] + phoff[s], mod 2^PW.
  - acc[s] ← acc[s] + fcw[s], mod 2^AW.
  - s ← s+1, wrapping at NCH−1.
- Phase is computed from the pre-add accumulator. Channels not scheduled in a cycle hold their accumulator value.
- `o_lut_ce` = 1 in RUN and FLUSH, 0 in IDLE.
- Tag pipe: a LUT_LAT-deep shift of {valid, ch}. It shifts only when `o_lut_ce`=1. Entries are valid=1 in RUN and valid=0 (bubble) in FLUSH.
- Output register: the pipe's tail drives `o_valid`/`o_ch`; `o_i`/`o_q` capture `i_lut_i`/`i_lut_q`. When `o_lut_ce`=0, `o_valid`=0 and data holds.
- Config handshake:
  - `o_cfg_ready` (registered) = 1 in IDLE and RUN, 0 in FLUSH.
  - On valid&ready, fcw/phoff of `i_cfg_ch` update next edge.
  - If the target is the slot being accumulated that cycle, the add uses the old FCW.
  - `i_cfg_ch` ≥ NCH: accepted and discarded.
- `i_sync`: all accumulators ← 0 at next edge, overriding that cycle's add. The phase issued in the sync cycle uses the pre-sync value. If a config write is accepted in the same cycle, both take effect.
- Deasserting `i_reset_n` mid-run clears everything immediately; in-flight lookup results are discarded by tag.

## Timing
- Slot issued at edge t (ce=1) → `o_valid`=1 with matching `o_ch` at t+LUT_LAT+1 (LUT_LAT lookup stages plus one output register).
- Steady RUN: one valid sample per cycle; each channel updated every NCH cycles.
- Stop: last valid sample is LUT_LAT+1 cycles after the last RUN cycle; `o_lut_ce` drops after LUT_LAT FLUSH cycles.
- `o_cfg_ready` falls the cycle after entering FLUSH and rises the cycle after leaving it.

## Configuration
- `NCO_DITHER_EN` defined: a 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1) advances every RUN cycle. The issued phase uses (acc[s] + (lfsr << (AW−PW−16)))[AW−1 −: PW] + phoff[s]. The stored accumulator is never dithered. Reset reloads the seed.
- Not defined: plain truncation as in Operation; no LFSR logic.

## Test plan
- NCH=4; fcw0=2^30, others 0; `i_en`=1 → ch0 phases 0, 1024, 2048, 3072, 0 every 4th cycle; ch1..3 phase 0.
- Lookup model with latency 5: issue at cycle t → `o_valid`=1 at t+6; `o_ch` sequence 0,1,2,3,0; I/Q match the model for each tagged phase.
- Drop `i_en` after 10 RUN cycles → exactly 10 valid outputs; `o_lut_ce` high 5 more cycles then 0; `o_cfg_ready`=0 during FLUSH.
- Config write to ch2 (fcw=2^28, phoff=512) in ch2's slot cycle → that add uses the old fcw; the next ch2 issue shows the new fcw and +512 offset.
- `i_sync` together with config write to ch1 → all accumulators 0 next cycle; ch1 fcw updated; the phase issued in the sync cycle is unaffected.
- Assert `i_reset_n`=0 mid-RUN → all outputs 0 asynchronously; after release, IDLE and `o_valid` stays 0 until 6 cycles after the first RUN.
